// File: rtl/ahb_pkg.sv
// Shared AHB bus types and constants for the slave-side blocks.
package ahb_pkg;

    localparam int unsigned AHB_DATA_WIDTH = 32;
    localparam int unsigned AHB_ADDR_WIDTH = 32;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-lane-enabled single-port word array: synchronous write, asynchronous read.
module ahb_sram_mem #(
    parameter  int unsigned DW    = 32,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned NB    = DW / 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [NB-1:0] be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting a local SRAM: pipelined acceptance, fixed wait states,
// byte-lane writes and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = AHB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = AHB_ADDR_WIDTH,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    Hclk,
    input  logic                    Hreset,
    input  logic                    Hsel,
    input  logic [ADDR_WIDTH-1:0]   Haddr,
    input  logic                    HWrite,
    input  logic [2:0]              Hsize,
    input  logic [2:0]              Hburst,
    input  logic [1:0]              Htrans,
    input  logic [DATA_WIDTH/8-1:0] Hstrb,
    input  logic [DATA_WIDTH-1:0]   HWdata,
    input  logic                    Hready,
    output logic                    Hreadyout,
    output logic [1:0]              Hresp,
    output logic [DATA_WIDTH-1:0]   HRdata
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned BB = $clog2(NB);
    localparam int unsigned IW = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            readyout_q;
    hresp_t          resp_q;
    logic [IW-1:0]   idx_q;
    logic            write_q;
    logic [NB-1:0]   mask_q;

    logic            accept, capture, acc_err;
    logic            bad_size, misaligned, out_of_range;
    logic [BB-1:0]   offset;
    logic [NB-1:0]   size_mask;
    int unsigned     nbytes;
    state_t          decode_st;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Address-phase decode: error checks and the size/offset lane mask.
    always_comb begin
        accept       = Hsel & Hready & Htrans[1];
        offset       = Haddr[BB-1:0];
        bad_size     = Hsize > 3'(BB);
        out_of_range = (Haddr >> BB) >= ADDR_WIDTH'(MEM_DEPTH);
        misaligned   = 1'b0;
        for (int unsigned b = 0; b < BB; b++) begin
            if (Haddr[b] && (b < 32'(Hsize))) misaligned = 1'b1;
        end
        acc_err = bad_size | misaligned | out_of_range;
        nbytes  = 32'd1 << Hsize;
        for (int unsigned i = 0; i < NB; i++) begin
            size_mask[i] = (i >= 32'(offset)) && (i < 32'(offset) + nbytes);
        end
        if (!accept)                decode_st = ST_IDLE;
        else if (acc_err)           decode_st = ST_ERR1;
        else if (WAIT_STATES > 0)   decode_st = ST_WAIT;
        else                        decode_st = ST_LAST;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE, ST_LAST, ST_ERR2: begin
                state_d = decode_st;
                capture = accept;
                cnt_d   = (decode_st == ST_WAIT) ? WAIT_LOAD : '0;
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_LAST;
                else             cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            readyout_q <= 1'b1;
            resp_q     <= HRESP_OKAY;
            idx_q      <= '0;
            write_q    <= 1'b0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readyout_q <= !(state_d inside {ST_WAIT, ST_ERR1});
            resp_q     <= (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
            if (capture) begin
                idx_q   <= Haddr[BB +: IW];
                write_q <= HWrite;
                mask_q  <= Hstrb & size_mask;
            end
        end
    end

    // Write commits on the edge that ends LAST, so a pipelined read sees it.
    ahb_sram_mem #(
        .DW    (DATA_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk_i   (Hclk),
        .we_i    ((state_q == ST_LAST) && write_q),
        .be_i    (mask_q),
        .addr_i  (idx_q),
        .wdata_i (HWdata),
        .rdata_o (mem_rdata)
    );

    assign Hreadyout = readyout_q;
    assign Hresp     = resp_q;
    assign HRdata    = ((state_q == ST_LAST) && !write_q) ? mem_rdata : '0;

    logic unused_ok;
    assign unused_ok = ^{Hburst, Htrans[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Three slaves (0, 1 and 2 wait states) on one bus, driven by a pipelined master
// with a reference memory model and an expected-response scoreboard.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int NS    = 3;
    localparam int DEPTH = 256;

    typedef struct {
        int          sl;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [3:0]  hstrb;
    logic        bus_sel;
    int          asl, dsl;
    logic [NS-1:0] hsel, ro;
    logic [1:0]  resp  [NS];
    logic [31:0] rdata [NS];
    logic        hready;

    cmd_t        cmdq[$];
    exp_t        expq[$];
    logic [31:0] model [NS][DEPTH];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign hready = ro[dsl];

    for (genvar k = 0; k < NS; k++) begin : g_s
        assign hsel[k] = bus_sel && (asl == k);
        ahb_sram_slave #(
            .DATA_WIDTH  (32),
            .ADDR_WIDTH  (32),
            .MEM_DEPTH   (DEPTH),
            .WAIT_STATES (k)
        ) u_dut (
            .Hclk      (clk),
            .Hreset    (rst),
            .Hsel      (hsel[k]),
            .Haddr     (haddr),
            .HWrite    (hwrite),
            .Hsize     (hsize),
            .Hburst    (hburst),
            .Htrans    (htrans),
            .Hstrb     (hstrb),
            .HWdata    (hwdata),
            .Hready    (hready),
            .Hreadyout (ro[k]),
            .Hresp     (resp[k]),
            .HRdata    (rdata[k])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one accepted transfer; updates the model on writes.
    function automatic exp_t predict(input cmd_t c);
        exp_t        e;
        logic [3:0]  lanes;
        int          nb, word, off;
        nb     = 1 << c.size;
        word   = int'(c.addr >> 2);
        off    = int'(c.addr % 4);
        e.err  = (c.size > 3'd2) || ((c.addr % nb) != 0) || (word >= DEPTH);
        e.cycles = e.err ? 2 : c.sl + 1;
        e.rdata  = '0;
        if (!e.err) begin
            lanes = '0;
            for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) lanes[i] = 1'b1;
            lanes = lanes & c.strb;
            if (c.wr) begin
                for (int i = 0; i < 4; i++)
                    if (lanes[i]) model[c.sl][word][8*i +: 8] = c.wdata[8*i +: 8];
            end else begin
                e.rdata = model[c.sl][word];
            end
        end
        return e;
    endfunction

    task automatic push(input int sl, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [3:0] strb, input logic [31:0] wdata);
        cmd_t c;
        c.sl = sl; c.wr = wr; c.addr = addr; c.size = size; c.strb = strb; c.wdata = wdata;
        cmdq.push_back(c);
    endtask

    task automatic run_cmds(input int exp_iters);
        cmd_t acmd;
        exp_t e;
        bit   av = 1'b0, dv = 1'b0, accept;
        int   cyc = 0, iters = 0;
        @(posedge clk); #1;
        while ((cmdq.size() > 0 || av || dv) && iters < 500) begin
            if (!av && cmdq.size() > 0) begin
                acmd = cmdq.pop_front();
                av   = 1'b1;
            end
            if (av) begin
                bus_sel = 1'b1; asl = acmd.sl; haddr = acmd.addr; hwrite = acmd.wr;
                hsize = acmd.size; hstrb = acmd.strb; htrans = 2'b10;
            end else begin
                bus_sel = 1'b0; htrans = 2'b00;
            end
            @(negedge clk);
            if (dv) begin
                cyc++;
                if (!hready) begin
                    chk("wait_resp", 64'(resp[dsl]), expq[0].err ? 64'd1 : 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("cycles", 64'(cyc), 64'(e.cycles));
                    chk("resp", 64'(resp[dsl]), e.err ? 64'd1 : 64'd0);
                    chk("rdata", 64'(rdata[dsl]), 64'(e.rdata));
                    dv = 1'b0;
                end
            end
            accept = av && hready;
            @(posedge clk); #1;
            if (accept) begin
                dv = 1'b1; av = 1'b0; cyc = 0; dsl = acmd.sl;
                hwdata = acmd.wdata;
                expq.push_back(predict(acmd));
            end
            iters++;
        end
        bus_sel = 1'b0; htrans = 2'b00;
        chk("drain", 64'(cmdq.size() + expq.size() + int'(av) + int'(dv)), 64'd0);
        if (exp_iters > 0) chk("throughput", 64'(iters), 64'(exp_iters));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus_sel = 1'b0; asl = 0; dsl = 0;
        haddr = '0; hwrite = 1'b0; hsize = 3'd2; hburst = '0; htrans = 2'b00;
        hstrb = '0; hwdata = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++) begin
            chk("rst_ready", 64'(ro[k]), 64'd1);
            chk("rst_resp", 64'(resp[k]), 64'd0);
            chk("rst_rdata", 64'(rdata[k]), 64'd0);
        end
        rst = 1'b0;

        // zero wait states: pipelined write then read of the same word
        push(0, 1, 32'h10, 3'd2, 4'hF, 32'hDEADBEEF);
        push(0, 0, 32'h10, 3'd2, 4'hF, 32'h0);
        run_cmds(3);

        // two wait states: single read is a 3-cycle data phase
        push(2, 1, 32'h04, 3'd2, 4'hF, 32'hA5A55A5A);
        run_cmds(0);
        push(2, 0, 32'h04, 3'd2, 4'hF, 32'h0);
        run_cmds(4);

        // byte lanes
        push(1, 1, 32'h20, 3'd2, 4'hF, 32'h11223344);
        push(1, 1, 32'h22, 3'd0, 4'h4, 32'h00AA0000);
        push(1, 0, 32'h20, 3'd2, 4'hF, 32'h0);
        push(1, 1, 32'h24, 3'd2, 4'hF, 32'h01020304);
        push(1, 1, 32'h26, 3'd1, 4'hF, 32'hBBCCDDEE);
        push(1, 0, 32'h24, 3'd2, 4'hF, 32'h0);
        push(1, 1, 32'h28, 3'd2, 4'hF, 32'hFFFFFFFF);
        push(1, 1, 32'h28, 3'd2, 4'h1, 32'h00000000);
        push(1, 0, 32'h28, 3'd2, 4'hF, 32'h0);
        run_cmds(0);

        // errors leave memory untouched
        push(1, 1, 32'h00, 3'd2, 4'hF, 32'hCAFEF00D);
        push(1, 1, 32'h03, 3'd1, 4'hF, 32'h12345678);
        push(1, 1, 32'(DEPTH * 4), 3'd2, 4'hF, 32'h87654321);
        push(1, 1, 32'h00, 3'd3, 4'hF, 32'h11111111);
        push(1, 0, 32'h00, 3'd2, 4'hF, 32'h0);
        run_cmds(0);

        // pipelined 4 writes + 4 reads at one wait state
        for (int i = 0; i < 4; i++) push(1, 1, 32'(4 * i), 3'd2, 4'hF, 32'h1000_0000 + 32'(i * 32'h0101));
        for (int i = 0; i < 4; i++) push(1, 0, 32'(4 * i), 3'd2, 4'hF, 32'h0);
        run_cmds(17);

        // reset during the wait cycle of a write
        push(2, 1, 32'h30, 3'd2, 4'hF, 32'h00000055);
        run_cmds(0);
        bus_sel = 1'b1; asl = 2; dsl = 2; haddr = 32'h30; hwrite = 1'b1;
        hsize = 3'd2; hstrb = 4'hF; htrans = 2'b10;
        @(posedge clk); #1;
        bus_sel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        chk("rst_wait_ready", 64'(ro[2]), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_abort_ready", 64'(ro[2]), 64'd1);
        chk("rst_abort_resp", 64'(resp[2]), 64'd0);
        chk("rst_abort_rdata", 64'(rdata[2]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(2, 0, 32'h30, 3'd2, 4'hF, 32'h0);
        run_cmds(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB responder that completes transfers issued by `ahb_master` against a local word-organised SRAM. It sits on the slave side of the bus decoder. It accepts pipelined address phases, inserts a programmable number of wait states, and honours `Hstrb` byte lanes. Illegal accesses return the two-cycle ERROR response.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width in bits; must be 32 or 64.
- `ADDR_WIDTH`, 32: address bus width.
- `MEM_DEPTH`, 256: number of `DATA_WIDTH` words; must be a power of two.
- `WAIT_STATES`, 1: wait cycles inserted in every OKAY data phase; range 0..15.

Ports:
- Clock and reset: one clock, `Hclk`. Reset `Hreset` is asynchronous and active-high.
- `Hclk` in, 1: bus clock; all state changes on the rising edge.
- `Hreset` in, 1: asynchronous, active-high reset.
- `Hsel` in, 1: slave select from the decoder.
- `Haddr` in, `ADDR_WIDTH`: transfer address; byte address, offset within this slave.
- `HWrite` in, 1: 1 = write, 0 = read.
- `Hsize` in, 3: transfer size, log2 of the byte count.
- `Hburst` in, 3: accepted but ignored; each beat is treated independently.
- `Htrans` in, 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Hstrb` in, `DATA_WIDTH/8`: byte write enables, qualified by the address phase.
- `HWdata` in, `DATA_WIDTH`: write data, valid in the data phase.
- `Hready` in, 1: bus-level ready; qualifies the address phase.
- `Hreadyout` out, 1: this slave's ready.
- `Hresp` out, 2: 00 OKAY, 01 ERROR; 10 and 11 are never driven.
- `HRdata` out, `DATA_WIDTH`: read data, valid when `Hreadyout`=1 on an OKAY read.

## Operation
Address phase acceptance:
- An address phase is accepted when `Hsel & Hready & Htrans[1]` is true.
- On acceptance, register address, write flag, size and the effective lane mask.
- Effective lane mask = `Hstrb` AND the size/offset-derived mask.

Error check, evaluated at acceptance. Any one of these makes the access an error:
- `Hsize` greater than log2(`DATA_WIDTH/8`).
- Address not aligned to `Hsize`.
- Word index `Haddr[..:log2(DATA_WIDTH/8)]` greater than or equal to `MEM_DEPTH`.

State machine:
- IDLE: `Hreadyout`=1, `Hresp`=OKAY.
  - Accepted valid access -> WAIT if `WAIT_STATES`>0, else LAST.
  - Accepted error access -> ERR1.
  - Otherwise stay in IDLE.
- WAIT: `Hreadyout`=0, `Hresp`=OKAY; counter loads `WAIT_STATES`-1 on entry.
  - Counter reaches 0 -> LAST.
- LAST: `Hreadyout`=1, `Hresp`=OKAY.
  - Write: `HWdata` is committed to the masked lanes at this edge.
  - Read: `HRdata` = mem[word index].
  - Next state is chosen exactly as from IDLE, because pipelined acceptance is allowed here.
- ERR1: `Hreadyout`=0, `Hresp`=ERROR -> ERR2.
- ERR2: `Hreadyout`=1, `Hresp`=ERROR.
  - No memory access occurs.
  - A new access may be accepted, with the same decode as IDLE.

Other transfer types:
- IDLE or BUSY with `Hsel`=1: zero-wait OKAY, no access.
- `Hsel`=0: no effect on state.

Data rules:
- `HRdata` is 0 outside read LAST cycles.
- Unselected lanes are never written.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, `Hreadyout`=1, `Hresp`=00, `HRdata`=0, wait counter 0.
- Reset asserted mid-transfer aborts the transfer; no write is committed.
- OKAY data-phase length is `WAIT_STATES`+1 cycles; ERROR data-phase length is 2 cycles.
- Back-to-back transfers:
  - The address of transfer N+1 may overlap the LAST or ERR2 cycle of transfer N.
  - Throughput is one beat per `WAIT_STATES`+1 cycles.
- Write-then-read to the same word, pipelined: the read returns the newly written data. The write commits at the LAST edge, before the read's LAST cycle.
- With `WAIT_STATES`=0, the read data path is combinational from the registered address.
- `Htrans`/`Haddr` changes while `Hreadyout`=0 are ignored, because `Hready` is low.

## Structure
- Shared package `ahb_pkg` holds:
  - `htrans_t` (IDLE/BUSY/NONSEQ/SEQ).
  - `hresp_t` (OKAY/ERROR/RETRY/SPLIT).
  - `HSIZE_BYTE`/`HSIZE_HALF`/`HSIZE_WORD`/`HSIZE_DWORD` constants.
  - Default `DATA_WIDTH`/`ADDR_WIDTH`.
- The state enum stays local to the module.
- One sub-module: `ahb_sram_mem`, a byte-lane-enabled single-port array with synchronous write and asynchronous read, parameterised by width and depth.

## Test plan
- `WAIT_STATES`=0:
  - Stimulus: NONSEQ write to 0x10, size 2, `Hstrb`=0xF, data 0xDEADBEEF; then read 0x10.
  - Required: `Hreadyout` never low; the read returns 0xDEADBEEF with OKAY.
- `WAIT_STATES`=2:
  - Stimulus: read 0x04.
  - Required: `Hreadyout` low for exactly 2 cycles, then high with valid data; total data phase is 3 cycles.
- Byte lanes:
  - Stimulus: after word 0x20 = 0x11223344, write byte 0x22 = 0xAA (size 0, `Hstrb`=0x4).
  - Required: a read of 0x20 returns 0x11AA3344.
- Errors:
  - Stimulus: halfword access to 0x03, then word access to `MEM_DEPTH`*4.
  - Required: each gets `Hreadyout`=0/ERROR, then `Hreadyout`=1/ERROR; memory is unchanged.
- Pipelining:
  - Stimulus: 4 back-to-back NONSEQ writes at 0x0/0x4/0x8/0xC, with `WAIT_STATES`=1, followed by 4 reads.
  - Required: throughput is one beat per 2 cycles; all read data matches.
- Reset:
  - Stimulus: assert `Hreset` during the WAIT cycle of a write to 0x30, which previously held 0x55.
  - Required: outputs return to reset values immediately; a read of 0x30 returns 0x55.
